// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package imem_pkg;

    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_HALT
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer; synchronous reset and flush both empty it.
module fetch_fifo #(
    parameter  int W     = 64,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: drives the ROM address, queues fetched words, handles redirects.
// Define FETCH_ALIGN_CHK_EN to trap misaligned redirect targets (sticky flag, fetch halts).
module imem_fetch_ctrl
    import imem_pkg::*;
#(
    parameter  int ADDRESS_WIDTH = 32,
    parameter  int DATA_WIDTH    = 8,
    parameter  int DEPTH         = 4,
    parameter  logic [ADDRESS_WIDTH-1:0] RESET_PC = '0,
    localparam int INSTR_W       = INSTR_BYTES * DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic [INSTR_W-1:0]       imem_rd,
    input  logic                     fetch_en,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [INSTR_W-1:0]       instr,
    output logic [ADDRESS_WIDTH-1:0] instr_pc,
    output logic                     fetch_misalign
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [INSTR_W-1:0]       instr;
        logic [ADDRESS_WIDTH-1:0] pc;
    } fetch_entry_t;

    fetch_state_t             state;
    fetch_state_t             state_next;
    logic [ADDRESS_WIDTH-1:0] fetch_pc;
    logic [ADDRESS_WIDTH-1:0] redirect_target;
    logic                     push;
    logic                     pop;
    logic                     halt_lock;
    fetch_entry_t             tail_entry;
    fetch_entry_t             head_entry;
    logic [CNT_W-1:0]         count;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     unused_fifo_full;

`ifdef FETCH_ALIGN_CHK_EN
    logic misalign_q;
    logic misalign_hit;

    assign misalign_hit = redirect_valid && (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst)               misalign_q <= 1'b0;
        else if (misalign_hit) misalign_q <= 1'b1;
    end

    assign halt_lock      = misalign_q || misalign_hit;
    assign fetch_misalign = misalign_q;
`else
    assign halt_lock      = 1'b0;
    assign fetch_misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= S_BOOT;
        else     state <= state_next;
    end

    // Boot, fetch and halt all follow fetch_en on the next cycle; a misalign trap pins halt.
    always_comb begin
        state_next = state;
        case (state)
            S_BOOT, S_FETCH, S_HALT: state_next = fetch_en ? S_FETCH : S_HALT;
            default:                 state_next = S_BOOT;
        endcase
        if (halt_lock) state_next = S_HALT;
    end

    // Decode handshake: a transfer happens on any cycle with instr_valid && instr_ready;
    // instr_valid never depends on instr_ready, and a redirect in that cycle still completes it.
    assign pop  = instr_valid && instr_ready;
    assign push = (state == S_FETCH) && !redirect_valid &&
                  ((count < CNT_W'(DEPTH)) || pop);

    assign redirect_target = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst)                 fetch_pc <= RESET_PC;
        else if (redirect_valid) fetch_pc <= redirect_target;
        else if (push)           fetch_pc <= fetch_pc + ADDRESS_WIDTH'(INSTR_BYTES);
    end

    assign tail_entry.instr = imem_rd;
    assign tail_entry.pc    = fetch_pc;

    fetch_fifo #(
        .W     ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (tail_entry),
        .head  (head_entry),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign unused_fifo_full = fifo_full;

    assign imem_addr   = fetch_pc;
    assign instr_valid = !fifo_empty;
    assign instr       = head_entry.instr;
    assign instr_pc    = head_entry.pc;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios then random traffic against a queue model.
module tb_imem_fetch_ctrl;

  localparam int AW = 32;
  localparam int IW = 32;
  localparam int DEPTH = 4;
  localparam logic [AW-1:0] RESET_PC = 32'h0;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rd;
  logic          fetch_en;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic [IW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          fetch_misalign;

  always #5 clk = ~clk;

  imem_fetch_ctrl #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (8),
    .DEPTH         (DEPTH),
    .RESET_PC      (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rd        (imem_rd),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .fetch_misalign (fetch_misalign)
  );

  // ROM word i holds 0x1000_0000 + i
  function automatic logic [IW-1:0] rom(input logic [AW-1:0] a);
    return 32'h1000_0000 + {2'b00, a[AW-1:2]};
  endfunction

  assign imem_rd = rom(imem_addr);

  // Scoreboard: instructions expected at the decode port, each {pc, instr}
  logic [AW+IW-1:0] exp_q[$];
  logic [AW-1:0]    m_pc;
  bit               m_fetching;
  bit               m_mis;
  int               checks = 0;
  int               errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    logic [AW+IW-1:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : '0;
    check("instr_valid", 64'(instr_valid), 64'(exp_q.size() != 0));
    check("instr", 64'(instr), 64'(head[IW-1:0]));
    check("instr_pc", 64'(instr_pc), 64'(head[AW+IW-1:IW]));
    check("imem_addr", 64'(imem_addr), 64'(m_pc));
    check("fetch_misalign", 64'(fetch_misalign), 64'(m_mis));
  endtask

  // Apply one cycle of inputs, advance the model by the same clock edge, then compare.
  task automatic step(input bit r, input bit en, input bit rv, input logic [AW-1:0] rpc,
                      input bit rdy);
    bit do_pop;
    bit do_push;
    rst = r; fetch_en = en; redirect_valid = rv; redirect_pc = rpc; instr_ready = rdy;
    if (r) begin
      exp_q.delete();
      m_pc = RESET_PC;
      m_fetching = 1'b0;
      m_mis = 1'b0;
    end else begin
      do_pop  = (exp_q.size() != 0) && rdy;
      do_push = m_fetching && !rv && ((exp_q.size() < DEPTH) || do_pop);
      if (do_pop) void'(exp_q.pop_front());
      if (rv) begin
        exp_q.delete();
        m_pc = {rpc[AW-1:2], 2'b00};
`ifdef FETCH_ALIGN_CHK_EN
        if (rpc[1:0] != 2'b00) m_mis = 1'b1;
`endif
      end else if (do_push) begin
        exp_q.push_back({m_pc, rom(m_pc)});
        m_pc = m_pc + 32'd4;
      end
      m_fetching = en && !m_mis;
    end
    @(posedge clk);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic run(input int n, input bit en, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, en, 1'b0, '0, rdy);
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b1;

    // Reset stream
    step(1'b1, 1'b1, 1'b0, '0, 1'b1);
    run(8, 1'b1, 1'b1);

    // Backpressure then drain
    run(10, 1'b1, 1'b0);
    run(8, 1'b1, 1'b1);

    // Redirect to 0x40 with a full queue while popping
    run(5, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h40, 1'b1);
    run(4, 1'b1, 1'b1);

    // Halt with three queued, then resume
    step(1'b0, 1'b1, 1'b1, 32'h100, 1'b0);
    run(3, 1'b1, 1'b0);
    run(6, 1'b0, 1'b1);
    run(5, 1'b1, 1'b1);

    // Misaligned redirect
    step(1'b0, 1'b1, 1'b1, 32'h42, 1'b1);
    run(4, 1'b1, 1'b1);

    // Mid-operation reset with two queued and fetch_pc at 0x80
    step(1'b1, 1'b1, 1'b0, '0, 1'b1);
    run(2, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 32'h78, 1'b0);
    run(2, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    run(4, 1'b1, 1'b1);

    // PC wrap
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
    run(5, 1'b1, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bit            r;
      bit            rv;
      logic [AW-1:0] rpc;
      r   = ($urandom_range(0, 99) < 2);
      rv  = ($urandom_range(0, 9) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : 32'($urandom);
      step(r, $urandom_range(0, 9) < 8, rv, rpc, $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
